// File: rtl/rollback_ctrl_pkg.sv
// rollback_ctrl_pkg: shared sizing constants and FSM state type for the rollback controller
package rollback_ctrl_pkg;
  localparam int NUM_ROB = 32;
  localparam int NUM_SUPER = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, DRAIN = 2'd2} ROLLBACK_STATE_t;
endpackage

// File: rtl/rob_age_select.sv
// rob_age_select: picks the oldest valid lane by modular ROB age, lowest lane on ties
module rob_age_select #(
  parameter int NUM_ROB = 32,
  parameter int NUM_SUPER = 2,
  localparam int IW = $clog2(NUM_ROB),
  localparam int LW = NUM_SUPER > 1 ? $clog2(NUM_SUPER) : 1
) (
  input  logic [IW-1:0]           head,
  input  logic [NUM_SUPER-1:0]    valid,
  input  logic [NUM_SUPER*IW-1:0] idx,
  output logic                    win_valid,
  output logic [LW-1:0]           win_lane,
  output logic [IW-1:0]           win_age
);
  logic [IW-1:0] ages [NUM_SUPER];
  for (genvar g = 0; g < NUM_SUPER; g++) begin : g_age
    assign ages[g] = idx[g*IW +: IW] - head;
  end
  always_comb begin
    win_valid = 1'b0;
    win_lane = '0;
    win_age = '0;
    for (int i = 0; i < NUM_SUPER; i++) begin
      if (valid[i] && (!win_valid || ages[i] < win_age)) begin
        win_valid = 1'b1;
        win_lane = LW'(i);
        win_age = ages[i];
      end
    end
  end
endmodule

// File: rtl/rollback_ctrl.sv
// rollback_ctrl: selects the oldest mispredicted branch and sequences the ROB rollback and fetch redirect
module rollback_ctrl #(
  parameter int NUM_ROB = rollback_ctrl_pkg::NUM_ROB,
  parameter int NUM_SUPER = rollback_ctrl_pkg::NUM_SUPER,
  parameter int DRAIN_CYCLES = 2,
  localparam int IW = $clog2(NUM_ROB),
  localparam int LW = NUM_SUPER > 1 ? $clog2(NUM_SUPER) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic [IW-1:0]           rob_head,
  input  logic [NUM_SUPER-1:0]    br_valid,
  input  logic [NUM_SUPER-1:0]    br_mispredict,
  input  logic [NUM_SUPER*IW-1:0] br_ROB_idx,
  input  logic [NUM_SUPER*64-1:0] br_target,
  output logic                    rollback_en,
  output logic [IW-1:0]           ROB_rollback_idx,
  output logic                    redirect_en,
  output logic [63:0]             redirect_PC,
  output logic                    stall_dispatch,
  output logic                    busy
);
  import rollback_ctrl_pkg::*;
  ROLLBACK_STATE_t state;
  logic [3:0] cnt;
  logic [IW-1:0] pend_idx, pend_age, win_age;
  logic [63:0] pend_tgt;
  logic win_valid, take, pulse;
  logic [LW-1:0] win_lane;
  rob_age_select #(.NUM_ROB(NUM_ROB), .NUM_SUPER(NUM_SUPER)) u_sel (
    .head(rob_head),
    .valid(br_valid & br_mispredict & {NUM_SUPER{en}}),
    .idx(br_ROB_idx),
    .win_valid(win_valid),
    .win_lane(win_lane),
    .win_age(win_age)
  );
  assign pend_age = pend_idx - rob_head;
  // a younger-or-equal winner while busy is already squashed by the pending rollback
  assign take = win_valid && (state == IDLE || win_age < pend_age);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pend_idx <= '0;
      pend_tgt <= '0;
    end else if (en) begin
      if (take) begin
        state <= FLUSH;
        pend_idx <= br_ROB_idx[int'(win_lane)*IW +: IW];
        pend_tgt <= br_target[int'(win_lane)*64 +: 64];
      end else if (state == FLUSH) begin
        state <= DRAIN;
        cnt <= 4'(DRAIN_CYCLES);
      end else if (state == DRAIN) begin
        cnt <= cnt - 4'd1;
        state <= cnt == 4'd1 ? IDLE : DRAIN;
      end
    end
  end
  assign pulse = en && state == FLUSH;
  assign rollback_en = pulse;
  assign redirect_en = pulse;
  assign ROB_rollback_idx = pulse ? pend_idx : '0;
  assign redirect_PC = pulse ? pend_tgt : '0;
  assign busy = state != IDLE;
  assign stall_dispatch = busy || win_valid;
endmodule
